// File: rtl/p_encoder_pkg.sv
// Shared constants and width helpers for the p_encoder leading-one detector.
package p_encoder_pkg;

  localparam int DEFAULT_WIDTH = 8;

  // Index width, never below 1 so a 1-bit index port stays legal.
  function automatic int clog2_safe(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

  // Power-of-two width the leading-one tree is built on (2**OUT_W).
  function automatic int pad_width(input int w);
    return 1 << clog2_safe(w);
  endfunction

endpackage

// File: rtl/p_encoder_core.sv
// Combinational log-depth leading-one tree: A -> {any_set, idx of highest set bit}.
module p_encoder_core
  import p_encoder_pkg::*;
#(
  parameter  int WIDTH = DEFAULT_WIDTH,
  localparam int OUT_W = clog2_safe(WIDTH)
) (
  input  logic [WIDTH-1:0] A,
  output logic [OUT_W-1:0] idx,
  output logic             any_set
);

  localparam int PAD_W = pad_width(WIDTH);

  logic [PAD_W-1:0] w_pad;

  // Zero padding at the MSB end cannot win over any real bit.
  if (PAD_W > WIDTH) begin : g_pad
    assign w_pad = {{(PAD_W - WIDTH){1'b0}}, A};
  end else begin : g_nopad
    assign w_pad = A;
  end

  // Level l holds PAD_W>>l nodes; node j merges nodes 2j (lower) and 2j+1 (upper) of level l-1.
  for (genvar l = 0; l <= OUT_W; l++) begin : g_lvl
    localparam int N = PAD_W >> l;
    logic [N-1:0]     w_any;
    logic [OUT_W-1:0] w_idx [N];

    for (genvar j = 0; j < N; j++) begin : g_node
      if (l == 0) begin : g_leaf
        assign w_any[j] = w_pad[j];
        assign w_idx[j] = OUT_W'(j);
      end else begin : g_pair
        assign w_any[j] = g_lvl[l-1].w_any[2*j+1] | g_lvl[l-1].w_any[2*j];
        assign w_idx[j] = g_lvl[l-1].w_any[2*j+1] ? g_lvl[l-1].w_idx[2*j+1]
                                                  : g_lvl[l-1].w_idx[2*j];
      end
    end
  end

  assign idx     = g_lvl[OUT_W].w_idx[0];
  assign any_set = g_lvl[OUT_W].w_any[0];

endmodule

// File: rtl/p_encoder.sv
// Registered priority encoder (index of the MSB set in A), 1-cycle latency.
// Optional registered A==0 flag output 'zero' when P_ENCODER_ZERO_FLAG_EN is defined.
module p_encoder
  import p_encoder_pkg::*;
#(
  parameter  int WIDTH = DEFAULT_WIDTH,
  localparam int OUT_W = clog2_safe(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  output logic [OUT_W-1:0] out
`ifdef P_ENCODER_ZERO_FLAG_EN
  ,
  output logic             zero
`endif
);

  logic [OUT_W-1:0] w_idx;
  logic             w_any_set;
  logic [OUT_W-1:0] r_out;

  p_encoder_core #(.WIDTH(WIDTH)) u_core (
    .A       (A),
    .idx     (w_idx),
    .any_set (w_any_set)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out <= '0;
    end else begin
      r_out <= w_any_set ? w_idx : '0;
    end
  end

  assign out = r_out;

`ifdef P_ENCODER_ZERO_FLAG_EN
  logic r_zero;

  // Resets to 1 so the pair {out=0, zero=1} reads as "no bit set".
  always_ff @(posedge clk) begin
    if (rst) begin
      r_zero <= 1'b1;
    end else begin
      r_zero <= ~w_any_set;
    end
  end

  assign zero = r_zero;
`endif

endmodule

// File: tb/tb_p_encoder.sv
// Self-checking bench for p_encoder at WIDTH=8, 5 and 16 against a log2 reference model.
`timescale 1ns/1ps
module tb_p_encoder;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  a8;
  logic [2:0]  out8;
  logic [4:0]  a5;
  logic [2:0]  out5;
  logic [15:0] a16;
  logic [3:0]  out16;
`ifdef P_ENCODER_ZERO_FLAG_EN
  logic        zero8, zero5, zero16;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  p_encoder #(.WIDTH(8)) dut (
    .clk (clk), .rst (rst), .A (a8), .out (out8)
`ifdef P_ENCODER_ZERO_FLAG_EN
    , .zero (zero8)
`endif
  );

  p_encoder #(.WIDTH(5)) dut5 (
    .clk (clk), .rst (rst), .A (a5), .out (out5)
`ifdef P_ENCODER_ZERO_FLAG_EN
    , .zero (zero5)
`endif
  );

  p_encoder #(.WIDTH(16)) dut16 (
    .clk (clk), .rst (rst), .A (a16), .out (out16)
`ifdef P_ENCODER_ZERO_FLAG_EN
    , .zero (zero16)
`endif
  );

  // Reference: floor(log2(v)) by repeated halving, 0 for v==0.
  function automatic int ref_msb(input int unsigned v);
    int n = 0;
    while (v > 1) begin
      v = v >> 1;
      n++;
    end
    return n;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    a8  = 8'd250;
    a5  = '0;
    a16 = '0;
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (out8 !== 3'd0) begin
        errors++;
        $display("FAIL reset_out: got %0d expected 0", out8);
      end
`ifdef P_ENCODER_ZERO_FLAG_EN
      checks++;
      if (zero8 !== 1'b1) begin
        errors++;
        $display("FAIL reset_zero: got %b expected 1", zero8);
      end
`endif
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (out8 !== 3'(ref_msb(250))) begin
      errors++;
      $display("FAIL reset_release: got %0d expected %0d", out8, ref_msb(250));
    end
  endtask

  // Drives vals on consecutive cycles; each result is checked one cycle later.
  task automatic test_directed(input string tag, input int unsigned vals[$]);
    int unsigned prev = 0;
    for (int i = 0; i <= vals.size(); i++) begin
      @(negedge clk);
      if (i > 0) begin
        checks++;
        if (out8 !== 3'(ref_msb(prev))) begin
          errors++;
          $display("FAIL %s A=%0d: got %0d expected %0d", tag, prev, out8, ref_msb(prev));
        end
`ifdef P_ENCODER_ZERO_FLAG_EN
        checks++;
        if (zero8 !== (prev == 0)) begin
          errors++;
          $display("FAIL %s_zero A=%0d: got %b expected %b", tag, prev, zero8, prev == 0);
        end
`endif
      end
      if (i < vals.size()) begin
        a8   = 8'(vals[i]);
        prev = vals[i];
      end
    end
  endtask

  task automatic test_boundary();
    test_directed("boundary", '{0, 1, 2});
  endtask

  task automatic test_mixed_bits();
    test_directed("mixed", '{35, 64, 128});
  endtask

  task automatic test_lower_bits_ignored();
    test_directed("lower_ignored", '{250, 73});
  endtask

  task automatic test_back_to_back();
    int unsigned seq[$];
    for (int v = 0; v < 256; v++) seq.push_back(v);
    test_directed("back_to_back", seq);
  endtask

  // Random A with occasional mid-stream synchronous reset.
  task automatic test_random_with_reset();
    int unsigned prev   = 0;
    bit          prev_r = 1'b0;
    int unsigned exp;
    for (int i = 0; i <= 300; i++) begin
      @(negedge clk);
      if (i > 0) begin
        exp = prev_r ? 0 : ref_msb(prev);
        checks++;
        if (out8 !== 3'(exp)) begin
          errors++;
          $display("FAIL random A=%0d rst=%b: got %0d expected %0d", prev, prev_r, out8, exp);
        end
`ifdef P_ENCODER_ZERO_FLAG_EN
        checks++;
        if (zero8 !== (prev_r || prev == 0)) begin
          errors++;
          $display("FAIL random_zero A=%0d rst=%b: got %b", prev, prev_r, zero8);
        end
`endif
      end
      if (i < 300) begin
        prev   = $urandom_range(0, 255);
        if ($urandom_range(0, 3) == 0) prev = prev >> $urandom_range(1, 7);
        prev_r = ($urandom_range(0, 15) == 0);
        a8     = 8'(prev);
        rst    = prev_r;
      end else begin
        rst = 1'b0;
      end
    end
  endtask

  // One-hot walk then all-ones on the WIDTH=5 and WIDTH=16 instances, plus random values.
  task automatic test_param_sweep();
    int unsigned p5  = 0;
    int unsigned p16 = 0;
    for (int k = 0; k <= 57; k++) begin
      @(negedge clk);
      if (k > 0) begin
        checks++;
        if (out5 !== 3'(ref_msb(p5))) begin
          errors++;
          $display("FAIL sweep_w5 A=%0d: got %0d expected %0d", p5, out5, ref_msb(p5));
        end
        checks++;
        if (out16 !== 4'(ref_msb(p16))) begin
          errors++;
          $display("FAIL sweep_w16 A=%0d: got %0d expected %0d", p16, out16, ref_msb(p16));
        end
`ifdef P_ENCODER_ZERO_FLAG_EN
        checks++;
        if (zero5 !== (p5 == 0) || zero16 !== (p16 == 0)) begin
          errors++;
          $display("FAIL sweep_zero: got %b/%b", zero5, zero16);
        end
`endif
      end
      if (k < 57) begin
        if (k < 16) begin
          p16 = 1 << k;
          p5  = (k < 5) ? (1 << k) : 31;
        end else if (k == 16) begin
          p16 = 16'hFFFF;
          p5  = 31;
        end else begin
          p16 = $urandom_range(0, 65535) >> $urandom_range(0, 15);
          p5  = $urandom_range(0, 31);
        end
        a5  = 5'(p5);
        a16 = 16'(p16);
      end
    end
  endtask

  initial begin
    test_reset();
    test_boundary();
    test_mixed_bits();
    test_lower_bits_ignored();
    test_back_to_back();
    test_random_with_reset();
    test_param_sweep();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
